regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port architectural register file, the successor of the single-cycle CPU's 2R/1W register unit.
- Supports NR read ports and NW write ports, configurable depth and width, and an optional hardwired zero register.
- A sequential clear engine zeroes every entry after reset or on request. A debug snapshot bus feeds the difftest/DPI side.
- Sits between decode (read addresses) and writeback (write ports) of single-issue or dual-issue cores.

Parameters:
- WIDTH, 32, data width per register.
- DEPTH, 32, number of registers; need not be a power of two.
- AW, 5, address width; must satisfy 2^AW >= DEPTH.
- NR, 2, number of read ports.
- NW, 1, number of write ports.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request a full clear sweep; sampled only in IDLE.
- rd_addr  in  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NR*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH].
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*AW  write addresses, packed as above.
- wr_data  in  NW*WIDTH  write data, packed as above.
- busy  out  1  high while the clear sweep is running.
- dbg_regfile  out  DEPTH*WIDTH  live contents; entry i at [i*WIDTH +: WIDTH].

Behaviour:
- All registers are flops; all state updates occur on posedge clk.
- FSM states: CLEAR, IDLE.
  - rst=1: next state CLEAR, clr_cnt <= 0, busy <= 1. Entry contents are not touched in the rst cycle.
  - CLEAR: entry[clr_cnt] <= 0 and clr_cnt <= clr_cnt+1 each cycle. When clr_cnt == DEPTH-1, write 0 to it, go to IDLE, and set busy <= 0.
  - Sweep takes exactly DEPTH cycles after rst deasserts. busy is high throughout and low on the following edge.
  - IDLE with clr_req=1: go to CLEAR with clr_cnt <= 0 and busy <= 1 on the next edge. Writes in that same cycle are still performed; the sweep later overwrites them.
  - clr_req during CLEAR is ignored; the sweep does not restart.
  - rst during CLEAR restarts the sweep from 0.
- Writes:
  - Accepted only in IDLE; all wr_en are ignored while busy=1.
  - Write to an address >= DEPTH is dropped silently.
  - Write to address 0 is dropped when ZERO_REG=1.
  - When several ports write the same address in one cycle, the highest-indexed port wins.
  - Distinct addresses from different ports all commit in the same cycle.
- Reads:
  - Combinational from the stored array, zero latency.
  - Return 0 for address >= DEPTH, for address 0 when ZERO_REG=1, and for any address while busy=1.
  - Without bypass, a read in the same cycle as a write to the same address returns the old value.
- dbg_regfile:
  - Reflects stored contents directly, with no bypass.
  - Entry 0 shows 0 when ZERO_REG=1.
- Outputs after the reset edge: busy=1, rd_data=0. dbg_regfile is undefined until the sweep covers each entry; an entry becomes 0 once the sweep has cleared it.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: each read port compares against all write ports in the current cycle, considered only when the write will actually commit (wr_en=1, IDLE, valid address, not hardwired zero). On a match, rd_data returns that port's wr_data, using the highest-indexed matching port. This is a combinational path from wr_* to rd_data.
- Undefined: no forwarding, and no combinational path from wr_* to rd_data.

Test Plan:
- Sweep: rst 1 cycle with DEPTH=32 -> busy stays 1 for exactly 32 cycles then falls. All dbg_regfile entries read 0, and a wr_en=1 issued mid-sweep to x5=0x1234 is not retained.
- Basic RW with NW=2: port0 writes x3=0xDEADBEEF and port1 writes x7=0x00000011 in one cycle -> next cycle rd_addr x3/x7 returns 0xDEADBEEF/0x00000011.
- Conflict: port0 writes x9=0xAAAA and port1 writes x9=0x5555 in one cycle -> x9 reads 0x5555. Separately, writing x0=0xFFFF with ZERO_REG=1 -> x0 reads 0.
- Same-cycle read/write: x4 holds 1, and the bench writes x4=2 while reading x4 -> reads 2 with REGFILE_BYPASS_EN and 1 without it; both builds read 2 the next cycle.
- Out-of-range with DEPTH=24, AW=5: write address 30 -> dbg_regfile is unchanged and reading address 30 returns 0.
- Clear request: fill x1..x31 with i, then pulse clr_req -> busy rises the next cycle and stays high 32 cycles. Afterwards all entries are 0, and a second clr_req pulsed mid-sweep does not extend busy.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port architectural register file: sequential clear sweep, optional zero register, debug snapshot.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  input  logic [NR*AW-1:0]       rd_addr,
  output logic [NR*WIDTH-1:0]    rd_data,
  input  logic [NW-1:0]          wr_en,
  input  logic [NW*AW-1:0]       wr_addr,
  input  logic [NW*WIDTH-1:0]    wr_data,
  output logic                   busy,
  output logic [DEPTH*WIDTH-1:0] dbg_regfile
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_clrCnt;
  logic [AW-1:0]    w_clrCntNext;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [NW-1:0]    w_wrValid;
  logic [NR*WIDTH-1:0] w_rdData;

  always_ff @(posedge clk) begin
    r_state  <= w_nextState;
    r_clrCnt <= w_clrCntNext;
  end

  always_comb begin
    w_nextState  = r_state;
    w_clrCntNext = r_clrCnt;
    if (rst) begin
      w_nextState  = S_CLEAR;
      w_clrCntNext = '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clrCnt == AW'(DEPTH - 1)) begin
            w_nextState = S_IDLE;
          end else begin
            w_clrCntNext = r_clrCnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            w_nextState  = S_CLEAR;
            w_clrCntNext = '0;
          end
        end
        default: w_nextState = S_CLEAR;
      endcase
    end
  end

  assign busy = (r_state == S_CLEAR);

  // A write port only takes effect if its address maps to a real, writable entry.
  always_comb begin
    w_wrValid = '0;
    for (int p = 0; p < NW; p++) begin
      w_wrValid[p] = wr_en[p]
                   && (int'(wr_addr[p*AW +: AW]) < DEPTH)
                   && !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
    end
  end

  // Later ports are visited last, so the highest-indexed port wins an address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_state == S_CLEAR) begin
          if (r_clrCnt == AW'(e)) r_mem[e] <= '0;
        end else begin
          for (int p = 0; p < NW; p++) begin
            if (w_wrValid[p] && (wr_addr[p*AW +: AW] == AW'(e))) begin
              r_mem[e] <= wr_data[p*WIDTH +: WIDTH];
            end
          end
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
    w_rdData = '0;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      v = '0;
      if (r_state == S_IDLE) begin
        for (int e = 0; e < DEPTH; e++) begin
          if ((a == AW'(e)) && !((ZERO_REG != 0) && (e == 0))) v = r_mem[e];
        end
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NW; p++) begin
          if (w_wrValid[p] && (wr_addr[p*AW +: AW] == a)) v = wr_data[p*WIDTH +: WIDTH];
        end
`endif
      end
      w_rdData[k*WIDTH +: WIDTH] = v;
    end
  end

  assign rd_data = w_rdData;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dbg
      assign dbg_regfile[gi*WIDTH +: WIDTH] = ((ZERO_REG != 0) && (gi == 0)) ? '0 : r_mem[gi];
    end
  endgenerate

endmodule
